// File: rtl/reaction_timer.sv
// Reaction-time trial controller: pseudo-random wait, GO LED, millisecond count
// until the button press, with false-start detection. Feeds the BCD display path.
module reaction_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        react,
    output logic        led_go,
    output logic        busy,
    output logic [24:0] time_taken,
    output logic        result_valid,
    output logic        false_start
);

    localparam int TICK_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);
    localparam int MS_W    = $clog2(MAX_MS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_GO,
        S_DONE,
        S_FALSE
    } state_t;

    state_t              state_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [DELAY_W-1:0]  delay_reg;
    logic [MS_W-1:0]     ms_reg;
    logic [15:0]         lfsr_reg;
    logic                start_prev_reg;
    logic                react_prev_reg;
    logic                led_go_reg;
    logic                busy_reg;
    logic [24:0]         time_taken_reg;
    logic                result_valid_reg;
    logic                false_start_reg;

    logic start_edge;
    logic react_edge;
    logic tick;
    logic lfsr_fb;

    assign start_edge = start & ~start_prev_reg;
    assign react_edge = react & ~react_prev_reg;
    assign tick       = (tick_cnt_reg == TICK_W'(TICKS_PER_MS - 1));
    assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            tick_cnt_reg     <= '0;
            delay_reg        <= '0;
            ms_reg           <= '0;
            lfsr_reg         <= 16'hACE1;
            start_prev_reg   <= 1'b0;
            react_prev_reg   <= 1'b0;
            led_go_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            time_taken_reg   <= '0;
            result_valid_reg <= 1'b0;
            false_start_reg  <= 1'b0;
        end else begin
            lfsr_reg       <= {lfsr_reg[14:0], lfsr_fb};
            start_prev_reg <= start;
            react_prev_reg <= react;
            // Free-running ms prescaler; each state entry below restarts it at 0.
            tick_cnt_reg   <= tick ? '0 : tick_cnt_reg + 1'b1;

            case (state_reg)
                S_IDLE, S_DONE, S_FALSE: begin
                    if (start_edge) begin
                        state_reg        <= S_ARMED;
                        tick_cnt_reg     <= '0;
                        delay_reg        <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_reg[RAND_BITS-1:0]);
                        time_taken_reg   <= '0;
                        result_valid_reg <= 1'b0;
                        false_start_reg  <= 1'b0;
                        busy_reg         <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (react_edge) begin
                        state_reg       <= S_FALSE;
                        tick_cnt_reg    <= '0;
                        busy_reg        <= 1'b0;
                        false_start_reg <= 1'b1;
                        time_taken_reg  <= '0;
                    end else if (tick) begin
                        delay_reg <= delay_reg - 1'b1;
                        if (delay_reg == DELAY_W'(1)) begin
                            state_reg    <= S_GO;
                            tick_cnt_reg <= '0;
                            ms_reg       <= '0;
                            led_go_reg   <= 1'b1;
                        end
                    end
                end
                S_GO: begin
                    // Press wins over a coincident tick, so the pre-increment count is captured.
                    if (react_edge) begin
                        state_reg        <= S_DONE;
                        tick_cnt_reg     <= '0;
                        time_taken_reg   <= 25'(ms_reg);
                        led_go_reg       <= 1'b0;
                        busy_reg         <= 1'b0;
                        result_valid_reg <= 1'b1;
                    end else if (tick && (ms_reg < MS_W'(MAX_MS))) begin
                        ms_reg <= ms_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    led_go_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign led_go       = led_go_reg;
    assign busy         = busy_reg;
    assign time_taken   = time_taken_reg;
    assign result_valid = result_valid_reg;
    assign false_start  = false_start_reg;

endmodule
